// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect from execute,
// and the decode-side valid/ready instruction handshake.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic        inst_pred;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, inst_pred,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, inst_pred,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I fetch stage: one outstanding imem request, 2-entry instruction queue to decode.
// Define IF_STATIC_PRED_EN for backward-taken static prediction of conditional branches.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst_n,
  if_fetch_if.master bus
);

  typedef enum logic [1:0] {RST, REQ, HOLD} state_t;

  state_t      state_q, state_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] tgt_q, tgt_nxt;
  logic        squash_q, squash_nxt;
  logic [1:0]  cnt_q, cnt_nxt;

  logic [31:0] q0_inst, q0_pc, q1_inst, q1_pc;
  logic        q0_pred, q1_pred;

  logic        pop, push, wr_hi, pred_hit;
  logic [31:0] seq_pc, redir_pc;

`ifdef IF_STATIC_PRED_EN
  function automatic logic is_bwd_branch(input logic [31:0] w);
    return (w[6:0] == 7'b1100011) && w[31];
  endfunction

  function automatic logic signed [31:0] b_imm(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  assign pred_hit = is_bwd_branch(bus.imem_rdata);
  assign seq_pc   = pred_hit ? addr_q + b_imm(bus.imem_rdata) : addr_q + 32'd4;
`else
  assign pred_hit = 1'b0;
  assign seq_pc   = addr_q + 32'd4;
`endif

  assign redir_pc = bus.redirect_pc & ~32'd3;

  // A squashed or redirected response never enters the queue.
  assign pop   = (cnt_q != 2'd0) && bus.inst_ready;
  assign push  = (state_q == REQ) && bus.imem_ack && !squash_q && !bus.redirect;
  assign wr_hi = (cnt_q == 2'd1) && !pop;

  always_comb begin
    cnt_nxt = cnt_q;
    if (bus.redirect)
      cnt_nxt = 2'd0;
    else if (push && !pop)
      cnt_nxt = cnt_q + 2'd1;
    else if (pop && !push)
      cnt_nxt = cnt_q - 2'd1;
  end

  always_comb begin
    state_nxt  = state_q;
    addr_nxt   = addr_q;
    tgt_nxt    = tgt_q;
    squash_nxt = squash_q;
    unique case (state_q)
      RST: begin
        state_nxt = REQ;
        if (bus.redirect) addr_nxt = redir_pc;
      end
      REQ: begin
        if (bus.imem_ack) begin
          squash_nxt = 1'b0;
          if (bus.redirect)
            addr_nxt = redir_pc;
          else if (squash_q)
            addr_nxt = tgt_q;
          else begin
            addr_nxt = seq_pc;
            if (cnt_nxt == 2'd2) state_nxt = HOLD;
          end
        end else if (bus.redirect) begin
          // Address must stay stable until the ack; remember where to go next.
          squash_nxt = 1'b1;
          tgt_nxt    = redir_pc;
        end
      end
      HOLD: begin
        if (bus.redirect) begin
          addr_nxt  = redir_pc;
          state_nxt = REQ;
        end else if (cnt_nxt != 2'd2) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RST;
      addr_q   <= RESET_PC;
      tgt_q    <= RESET_PC;
      squash_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_nxt;
      addr_q   <= addr_nxt;
      tgt_q    <= tgt_nxt;
      squash_q <= squash_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  // Shift queue: entry 0 is always the head presented to decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0_inst <= 32'd0;
      q0_pc   <= 32'd0;
      q0_pred <= 1'b0;
      q1_inst <= 32'd0;
      q1_pc   <= 32'd0;
      q1_pred <= 1'b0;
    end else begin
      if (pop) begin
        q0_inst <= q1_inst;
        q0_pc   <= q1_pc;
        q0_pred <= q1_pred;
      end
      if (push) begin
        if (wr_hi) begin
          q1_inst <= bus.imem_rdata;
          q1_pc   <= addr_q;
          q1_pred <= pred_hit;
        end else begin
          q0_inst <= bus.imem_rdata;
          q0_pc   <= addr_q;
          q0_pred <= pred_hit;
        end
      end
    end
  end

  assign bus.imem_req   = (state_q == REQ);
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = (cnt_q != 2'd0);
  assign bus.inst       = q0_inst;
  assign bus.inst_pc    = q0_pc;
  assign bus.inst_pred  = q0_pred;
  assign bus.opcode     = (cnt_q != 2'd0) ? q0_inst[6:0] : 7'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a memory responder with programmable latency and ack
// budget, directed scenarios pushing expected PCs, and a monitor checking every delivery.
module tb_if_fetch;
  logic clk = 1'b0;
  logic rst_n;

  if_fetch_if bus();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef IF_STATIC_PRED_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  int          checks, passes, fails;
  int          lat, ack_limit, ack_cnt, wait_cnt;
  bit          bp;
  logic [31:0] exp_pc   [64];
  logic        exp_pred [64];
  int          wr, rd;

  function automatic logic [31:0] memfn(input logic [31:0] a, input bit b);
    if (b && a == 32'h10) return 32'hFE00_0EE3;
    return (a << 7) | 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic hold_reset(input bit rdy);
    rst_n          = 1'b0;
    bus.redirect   = 1'b0;
    bus.inst_ready = rdy;
    repeat (2) tick();
  endtask

  task automatic expect_pc(input logic [31:0] pc, input bit p);
    exp_pc[wr]   = pc;
    exp_pred[wr] = p;
    wr++;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_imem_req"},   32'(bus.imem_req),   32'd0);
    chk({p, "_imem_addr"},  bus.imem_addr,       32'd0);
    chk({p, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({p, "_inst"},       bus.inst,            32'd0);
    chk({p, "_inst_pc"},    bus.inst_pc,         32'd0);
    chk({p, "_opcode"},     32'(bus.opcode),     32'd0);
    chk({p, "_inst_pred"},  32'(bus.inst_pred),  32'd0);
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
    chk("drain_outstanding", 32'(wr - rd), 32'd0);
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0;
    wr = 0; rd = 0;
    lat = 0; ack_limit = 0; ack_cnt = 0; wait_cnt = 0; bp = 1'b0;
    rst_n          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.redirect   = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.inst_ready = 1'b0;

    fork
      begin : mem_model
        forever begin
          @(posedge clk);
          #2;
          if (rst_n && bus.imem_req && ack_cnt < ack_limit) begin
            if (wait_cnt >= lat) begin
              bus.imem_ack   = 1'b1;
              bus.imem_rdata = memfn(bus.imem_addr, bp);
              ack_cnt++;
              wait_cnt = 0;
            end else begin
              bus.imem_ack = 1'b0;
              wait_cnt++;
            end
          end else begin
            bus.imem_ack = 1'b0;
            wait_cnt = 0;
          end
        end
      end
      begin : monitor
        forever begin
          logic [31:0] w;
          @(negedge clk);
          if (!rst_n) rd = wr;
          else begin
            if (bus.imem_req && bus.imem_ack)
              chk("push_while_full", 32'(dut.cnt_q == 2'd2), 32'd0);
            if (bus.inst_valid && bus.inst_ready) begin
              if (rd == wr) begin
                checks++;
                fails++;
                $display("FAIL unexpected_delivery: got pc 0x%08h, expected no instruction", bus.inst_pc);
              end else begin
                w = memfn(exp_pc[rd], bp);
                chk("inst_pc",   bus.inst_pc,         exp_pc[rd]);
                chk("inst",      bus.inst,            w);
                chk("opcode",    32'(bus.opcode),     32'(w[6:0]));
                chk("inst_pred", 32'(bus.inst_pred),  32'(exp_pred[rd]));
                rd++;
              end
            end
          end
        end
      end
      begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
      end
    join_none

    // Reset values, then zero-wait streaming with decode always ready.
    hold_reset(1'b1);
    chk_reset("rst");
    lat = 0; bp = 1'b0;
    ack_limit = ack_cnt + 6;
    for (int i = 0; i < 6; i++) expect_pc(32'(4 * i), 1'b0);
    rst_n = 1'b1;
    smp();
    chk("t1_req_c0", 32'(bus.imem_req), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(); smp();
      chk("t1_addr", bus.imem_addr, 32'(4 * (k - 1)));
      chk("t1_req", 32'(bus.imem_req), 32'd1);
      chk("t1_valid", 32'(bus.inst_valid), 32'(k >= 2));
      if (k >= 2) chk("t1_inst_pc", bus.inst_pc, 32'(4 * (k - 2)));
    end
    drain(8);

    // Decode stalled: queue fills, FSM holds, then resumes at PC 8.
    hold_reset(1'b0);
    lat = 0;
    ack_limit = ack_cnt + 8;
    for (int i = 0; i < 8; i++) expect_pc(32'(4 * i), 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    smp();
    chk("t2_req_c3", 32'(bus.imem_req), 32'd0);
    chk("t2_addr_c3", bus.imem_addr, 32'h8);
    chk("t2_valid_c3", 32'(bus.inst_valid), 32'd1);
    chk("t2_pc_c3", bus.inst_pc, 32'h0);
    repeat (3) tick();
    smp();
    chk("t2_req_c6", 32'(bus.imem_req), 32'd0);
    tick();
    bus.inst_ready = 1'b1;
    smp();
    chk("t2_req_c7", 32'(bus.imem_req), 32'd0);
    tick(); smp();
    chk("t2_req_c8", 32'(bus.imem_req), 32'd1);
    chk("t2_addr_c8", bus.imem_addr, 32'h8);
    drain(20);

    // Slow memory; redirect (with stray low bits) during the second wait cycle.
    hold_reset(1'b1);
    lat = 3;
    ack_limit = ack_cnt + 4;
    expect_pc(32'h0, 1'b0);
    expect_pc(32'h100, 1'b0);
    expect_pc(32'h104, 1'b0);
    rst_n = 1'b1;
    repeat (6) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    smp();
    chk("t3_addr_c6", bus.imem_addr, 32'h4);
    tick();
    bus.redirect = 1'b0;
    smp();
    chk("t3_addr_c7", bus.imem_addr, 32'h4);
    chk("t3_req_c7", 32'(bus.imem_req), 32'd1);
    chk("t3_valid_c7", 32'(bus.inst_valid), 32'd0);
    tick(); smp();
    chk("t3_addr_c8", bus.imem_addr, 32'h4);
    tick(); smp();
    chk("t3_addr_c9", bus.imem_addr, 32'h100);
    chk("t3_req_c9", 32'(bus.imem_req), 32'd1);
    chk("t3_opcode_c9", 32'(bus.opcode), 32'd0);
    drain(20);

    // Redirect coincident with an ack and a pop.
    hold_reset(1'b1);
    lat = 0;
    ack_limit = ack_cnt + 4;
    expect_pc(32'h0, 1'b0);
    expect_pc(32'h200, 1'b0);
    expect_pc(32'h204, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    smp();
    chk("t4_valid_c2", 32'(bus.inst_valid), 32'd1);
    chk("t4_pc_c2", bus.inst_pc, 32'h0);
    tick();
    bus.redirect = 1'b0;
    smp();
    chk("t4_valid_c3", 32'(bus.inst_valid), 32'd0);
    chk("t4_opcode_c3", 32'(bus.opcode), 32'd0);
    chk("t4_addr_c3", bus.imem_addr, 32'h200);
    chk("t4_req_c3", 32'(bus.imem_req), 32'd1);
    drain(10);

    // Asynchronous reset mid-cycle with a request outstanding and a word queued.
    hold_reset(1'b0);
    lat = 0;
    ack_limit = ack_cnt + 1;
    expect_pc(32'h0, 1'b0);
    rst_n = 1'b1;
    repeat (4) tick();
    smp();
    chk("t5_req_pre", 32'(bus.imem_req), 32'd1);
    chk("t5_addr_pre", bus.imem_addr, 32'h4);
    chk("t5_valid_pre", 32'(bus.inst_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("t5_async");
    tick(); tick();
    ack_limit = ack_cnt + 2;
    bus.inst_ready = 1'b1;
    expect_pc(32'h0, 1'b0);
    expect_pc(32'h4, 1'b0);
    rst_n = 1'b1;
    smp();
    tick(); smp();
    chk("t5_restart_addr", bus.imem_addr, 32'h0);
    chk("t5_restart_req", 32'(bus.imem_req), 32'd1);
    drain(8);

    // Backward conditional branch at 0x10.
    hold_reset(1'b1);
    lat = 0;
    bp = 1'b1;
    ack_limit = ack_cnt + 6;
    expect_pc(32'h0, 1'b0);
    expect_pc(32'h4, 1'b0);
    expect_pc(32'h8, 1'b0);
    expect_pc(32'hC, 1'b0);
    expect_pc(32'h10, PRED_EN);
    expect_pc(PRED_EN ? 32'hC : 32'h14, 1'b0);
    rst_n = 1'b1;
    repeat (6) tick();
    smp();
    chk("t6_next_addr", bus.imem_addr, PRED_EN ? 32'hC : 32'h14);
    drain(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
